inst_fetch_resp: RTL and testbench

- Memory-side responder for the instruction-fetch stage. It takes the fetch request (chip enable, physical address, fetch-stage exception) and runs one read transaction per request on a ready/ack instruction bus.
- It returns the instruction word, or an exception, to the IF/ID boundary, and stalls the pipeline while a transaction is outstanding.
- A bus watchdog converts a missing ack into an instruction bus error.

---
 rtl/inst_fetch_resp.sv | 189 ++++++++++++++++++
 tb/tb_inst_fetch_resp.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_resp.sv
// rtl/inst_fetch_resp.sv - instruction-fetch bus responder with watchdog
//
// Purpose:
//   Turns a fetch-stage request into one ready/ack read on the instruction
//   bus and returns the word (or an exception) to the IF/ID boundary as a
//   one-cycle pulse. The pipeline is stalled while a read is outstanding.
//   A watchdog converts a missing ack into an instruction bus error.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ce_i                fetch request valid
//   inst_addr_i         physical fetch address
//   vaddr_i             virtual fetch address (reported on errors)
//   exc_code_i          fetch-stage exception code (EC_NONE = none)
//   flush_i             cancels the current fetch
//   stall_o             combinational pipeline stall request
//   inst_o              fetched instruction
//   inst_valid_o        one-cycle pulse qualifying inst_o / exc_code_o
//   exc_code_o          exception code accompanying inst_valid_o
//   exc_badvaddr_o      faulting virtual address, zero without exception
//   mem_req_o           bus read request, held until acked
//   mem_addr_o          registered bus address
//   mem_ack_i           bus acknowledge, mem_rdata_i valid same cycle
//   mem_rdata_i         bus read data

module inst_fetch_resp #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] vaddr_i,
  input  logic [4:0]  exc_code_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic [4:0]  exc_code_o,
  output logic [31:0] exc_badvaddr_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  // Shared exception codes
  localparam logic [4:0] EC_NONE = 5'h10;
  localparam logic [4:0] EC_ADEL = 5'h04;
  localparam logic [4:0] EC_IBE  = 5'h06;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic start;
  logic exc_req;
  logic timeout;

  // start is gated by rst so stall_o drops together with the async reset
  // even if the fetch stage keeps ce_i asserted.
  assign start   = ~rst & (state_q == IDLE) & ce_i & ~flush_i & (exc_code_i == EC_NONE);
  assign exc_req = (state_q == IDLE) & ce_i & ~flush_i & (exc_code_i != EC_NONE);
  assign timeout = (cnt_q == TIMEOUT_C);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    vaddr_d      = vaddr_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    exc_code_d   = exc_code_q;
    badvaddr_d   = badvaddr_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mem_addr_d = inst_addr_i;
          vaddr_d    = vaddr_i;
          mem_req_d  = 1'b1;
          cnt_d      = '0;
          state_d    = BUSY;
        end else if (exc_req) begin
          inst_valid_d = 1'b1;
          inst_d       = 32'h0;
          exc_code_d   = exc_code_i;
          badvaddr_d   = vaddr_i;
        end
      end

      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          // A flush in the ack cycle discards the data silently.
          if (!flush_i) begin
            inst_valid_d = 1'b1;
            inst_d       = mem_rdata_i;
            exc_code_d   = EC_NONE;
            badvaddr_d   = 32'h0;
          end
        end else if (timeout) begin
          // Checked before flush: entering DRAIN with the counter already at
          // TIMEOUT would let it run past the compare value and never exit.
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (!flush_i) begin
            inst_valid_d = 1'b1;
            inst_d       = 32'h0;
            exc_code_d   = EC_IBE;
            badvaddr_d   = vaddr_q;
          end
        end else if (flush_i) begin
          // Request stays up: a bus request is never withdrawn before ack.
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_ack_i || timeout) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      vaddr_q      <= 32'h0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'h0;
      inst_q       <= 32'h0;
      inst_valid_q <= 1'b0;
      exc_code_q   <= EC_NONE;
      badvaddr_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vaddr_q      <= vaddr_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      exc_code_q   <= exc_code_d;
      badvaddr_q   <= badvaddr_d;
    end
  end

  assign stall_o        = start | (state_q == BUSY) | (state_q == DRAIN);
  assign inst_o         = inst_q;
  assign inst_valid_o   = inst_valid_q;
  assign exc_code_o     = exc_code_q;
  assign exc_badvaddr_o = badvaddr_q;
  assign mem_req_o      = mem_req_q;
  assign mem_addr_o     = mem_addr_q;

  // EC_ADEL is part of the shared code set; it only ever arrives on
  // exc_code_i and is forwarded unchanged.
  logic unused_adel;
  assign unused_adel = ^EC_ADEL;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// tb/tb_inst_fetch_resp.sv - scoreboard bench for inst_fetch_resp
module tb_inst_fetch_resp;

  localparam logic [4:0] EC_NONE = 5'h10;
  localparam logic [4:0] EC_ADEL = 5'h04;
  localparam logic [4:0] EC_IBE  = 5'h06;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i;
  logic [31:0] inst_addr_i;
  logic [31:0] vaddr_i;
  logic [4:0]  exc_code_i;
  logic        flush_i;
  logic        stall_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic [4:0]  exc_code_o;
  logic [31:0] exc_badvaddr_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  inst_fetch_resp #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .ce_i           (ce_i),
    .inst_addr_i    (inst_addr_i),
    .vaddr_i        (vaddr_i),
    .exc_code_i     (exc_code_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .inst_o         (inst_o),
    .inst_valid_o   (inst_valid_o),
    .exc_code_o     (exc_code_o),
    .exc_badvaddr_o (exc_badvaddr_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_ack_i      (mem_ack_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  exc;
    logic [31:0] bad;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [4:0] e, input logic [31:0] b);
    exp_t x;
    x.inst = i; x.exc = e; x.bad = b;
    exp_q.push_back(x);
  endtask

  // Monitor: every valid pulse is matched against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && inst_valid_o) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid actual=inst %h exc %h expected=no pulse", inst_o, exc_code_o);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("sb_inst", inst_o, x.inst);
        chk("sb_exc", {27'h0, exc_code_o}, {27'h0, x.exc});
        chk("sb_badvaddr", exc_badvaddr_o, x.bad);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Fetch with ack in BUSY cycle k; pulse expected in cycle k+1.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] va,
                          input logic [31:0] rd, input int k, input string nm);
    int st;
    st = 0;
    next_cycle();
    ce_i = 1'b1; inst_addr_i = a; vaddr_i = va; exc_code_i = EC_NONE;
    push(rd, EC_NONE, 32'h0);
    @(negedge clk);
    if (stall_o) st++;
    chk({nm, "_req_c0"}, {31'h0, mem_req_o}, 32'h0);
    for (int c = 1; c <= k; c++) begin
      next_cycle();
      ce_i = 1'b0;
      mem_ack_i = (c == k);
      mem_rdata_i = (c == k) ? rd : 32'h0;
      @(negedge clk);
      if (stall_o) st++;
      chk({nm, "_req"}, {31'h0, mem_req_o}, 32'h1);
      chk({nm, "_addr"}, mem_addr_o, a);
      chk({nm, "_novalid"}, {31'h0, inst_valid_o}, 32'h0);
    end
    next_cycle();
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    @(negedge clk);
    chk({nm, "_valid"}, {31'h0, inst_valid_o}, 32'h1);
    chk({nm, "_stall_low"}, {31'h0, stall_o}, 32'h0);
    chk({nm, "_req_low"}, {31'h0, mem_req_o}, 32'h0);
    chk({nm, "_stall_cycles"}, st, k + 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ce_i = 1'b0; inst_addr_i = 32'h0; vaddr_i = 32'h0;
    exc_code_i = EC_NONE; flush_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst_stall", {31'h0, stall_o}, 32'h0);
    chk("rst_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("rst_exc", {27'h0, exc_code_o}, {27'h0, EC_NONE});
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_bad", exc_badvaddr_o, 32'h0);

    // Normal fetch, ack 3 cycles after request
    do_fetch(32'h1FC00000, 32'hBFC00000, 32'h3C1A8000, 3, "norm");
    // Ack in the first BUSY cycle
    do_fetch(32'h00000040, 32'h80000040, 32'h24020001, 1, "fast");

    // Misaligned fetch: no bus access, pulse next cycle
    next_cycle();
    ce_i = 1'b1; exc_code_i = EC_ADEL; vaddr_i = 32'hBFC00002; inst_addr_i = 32'h1FC00002;
    push(32'h0, EC_ADEL, 32'hBFC00002);
    @(negedge clk);
    chk("adel_stall", {31'h0, stall_o}, 32'h0);
    chk("adel_req", {31'h0, mem_req_o}, 32'h0);
    next_cycle();
    ce_i = 1'b0; exc_code_i = EC_NONE;
    @(negedge clk);
    chk("adel_valid", {31'h0, inst_valid_o}, 32'h1);
    chk("adel_req1", {31'h0, mem_req_o}, 32'h0);

    // Timeout: BUSY cycles 1..5 (counter 0..4), IBE pulse in cycle 6
    next_cycle();
    ce_i = 1'b1; inst_addr_i = 32'h00001000; vaddr_i = 32'h80001000;
    push(32'h0, EC_IBE, 32'h80001000);
    next_cycle();
    ce_i = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("to_req", {31'h0, mem_req_o}, 32'h1);
      chk("to_stall", {31'h0, stall_o}, 32'h1);
      chk("to_novalid", {31'h0, inst_valid_o}, 32'h0);
      next_cycle();
    end
    @(negedge clk);
    chk("to_valid", {31'h0, inst_valid_o}, 32'h1);
    chk("to_req_low", {31'h0, mem_req_o}, 32'h0);
    chk("to_stall_low", {31'h0, stall_o}, 32'h0);

    // Flush in 2nd BUSY cycle, ack two cycles later: no pulse
    next_cycle();
    ce_i = 1'b1; inst_addr_i = 32'h00002000; vaddr_i = 32'h80002000;
    next_cycle();
    ce_i = 1'b0;
    next_cycle();
    flush_i = 1'b1;
    next_cycle();
    flush_i = 1'b0;
    @(negedge clk);
    chk("fl_drain_req", {31'h0, mem_req_o}, 32'h1);
    chk("fl_drain_stall", {31'h0, stall_o}, 32'h1);
    next_cycle();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("fl_ack_req", {31'h0, mem_req_o}, 32'h1);
    chk("fl_ack_stall", {31'h0, stall_o}, 32'h1);
    next_cycle();
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    @(negedge clk);
    chk("fl_req_low", {31'h0, mem_req_o}, 32'h0);
    chk("fl_stall_low", {31'h0, stall_o}, 32'h0);
    chk("fl_novalid", {31'h0, inst_valid_o}, 32'h0);

    // Back-to-back: second request issued in the first valid-pulse cycle
    next_cycle();
    ce_i = 1'b1; inst_addr_i = 32'h00000100; vaddr_i = 32'h80000100;
    push(32'h11111111, EC_NONE, 32'h0);
    next_cycle();
    ce_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h11111111;
    @(negedge clk);
    chk("b2b_addr1", mem_addr_o, 32'h00000100);
    next_cycle();
    mem_ack_i = 1'b0; ce_i = 1'b1; inst_addr_i = 32'h00000104; vaddr_i = 32'h80000104;
    push(32'h22222222, EC_NONE, 32'h0);
    @(negedge clk);
    chk("b2b_valid1", {31'h0, inst_valid_o}, 32'h1);
    chk("b2b_stall_start", {31'h0, stall_o}, 32'h1);
    next_cycle();
    ce_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h22222222;
    @(negedge clk);
    chk("b2b_addr2", mem_addr_o, 32'h00000104);
    chk("b2b_gap", {31'h0, inst_valid_o}, 32'h0);
    next_cycle();
    mem_ack_i = 1'b0;
    @(negedge clk);
    chk("b2b_valid2", {31'h0, inst_valid_o}, 32'h1);
    chk("b2b_stall_low", {31'h0, stall_o}, 32'h0);

    // Reset asserted asynchronously mid-BUSY
    next_cycle();
    ce_i = 1'b1; inst_addr_i = 32'h00003000; vaddr_i = 32'h80003000;
    next_cycle();
    ce_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", {31'h0, mem_req_o}, 32'h0);
    chk("arst_stall", {31'h0, stall_o}, 32'h0);
    chk("arst_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("arst_inst", inst_o, 32'h0);
    chk("arst_addr", mem_addr_o, 32'h0);
    chk("arst_exc", {27'h0, exc_code_o}, {27'h0, EC_NONE});
    chk("arst_bad", exc_badvaddr_o, 32'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("arst_idle_req", {31'h0, mem_req_o}, 32'h0);
    chk("arst_idle_stall", {31'h0, stall_o}, 32'h0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
